// File: rtl/int_divider_pkg.sv
// Shared types for the RV32M multi-cycle divider.
// Op encodings, FSM states and counter sizing.
package int_divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic logic op_signed(input div_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_rem(input div_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift, trial subtract, restore.
// The quotient bit is shifted into the dividend's vacated LSB.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Remainder stays below the divisor, so WIDTH+1 bits hold the trial.
  assign shifted = {rem_i, dvd_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_i};
  assign qbit_o  = ~trial[WIDTH];
  assign rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign dvd_o   = {dvd_i[WIDTH-2:0], qbit_o};

endmodule

// File: rtl/int_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// start/busy/done handshake; flush aborts an in-flight divide.
module int_divider
  import int_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       div_ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = '1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             sel_q, sel_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  div_op_e          op_in;
  logic             sgn_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] spec_res;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic             step_qbit;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign op_in  = div_op_e'(div_ctrl);
  assign sgn_in = op_signed(op_in);
  assign a_mag  = (sgn_in && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn_in && b[WIDTH-1]) ? -b : b;
  assign b_zero = (b == '0);
  assign ovf    = sgn_in && (a == MIN) && (b == ONES);

  // Divide-by-zero and signed overflow bypass the iterative datapath.
  always_comb begin
    spec_res = '0;
    if (b_zero) begin
      spec_res = op_rem(op_in) ? a : ONES;
    end else if (ovf) begin
      spec_res = op_rem(op_in) ? '0 : a;
    end
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .dvd_i  (dvd_q),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .dvd_o  (step_dvd),
    .qbit_o (step_qbit)
  );

  assign q_fix = qneg_q ? -dvd_q : dvd_q;
  assign r_fix = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    sel_d   = sel_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          sel_d  = op_rem(op_in);
          qneg_d = sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = sgn_in & a[WIDTH-1];
          rem_d  = '0;
          cnt_d  = '0;
          dvd_d  = a_mag;
          dvs_d  = b_mag;
          if (b_zero || ovf) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d   = sel_q ? r_fix : q_fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      sel_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = res_q;

  // step_qbit is folded into step_dvd; kept as a port for visibility.
  logic unused_ok;
  assign unused_ok = step_qbit;

endmodule
